// File: rtl/nibble_serial_sub16.sv
// nibble_serial_sub16: multi-cycle subtractor, diff = a - b.
// One SLICE_W-bit slice of a + ~b + carry is evaluated per clock, LSB slice
// first, with the carry held in a register between slices. Reports signed
// overflow, unsigned borrow and zero; optionally saturates on signed overflow.
//
// Handshake: start is a request sampled on any rising edge while the block is
// not in RUN (IDLE or DONE). An accepted start latches a, b and sat_en; busy is
// high during the RUN cycles and done pulses for exactly one cycle when diff,
// ovfl, borrow and zero become valid. Those outputs then hold until the final
// slice of the next operation. There is no back-pressure and no queueing: a
// start seen during RUN is dropped.
module nibble_serial_sub16 #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             ovfl,
  output logic             borrow,
  output logic             zero
);

  localparam int NSL   = WIDTH / SLICE_W;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   op_a;     // latched minuend
  logic [WIDTH-1:0]   op_nb;    // latched inverted subtrahend
  logic [WIDTH-1:0]   res;      // partial result, filled slice by slice
  logic               sat_q;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [SLICE_W:0]   slice_sum;
  logic [WIDTH-1:0]   res_next;
  logic               ovfl_c;
  logic [WIDTH-1:0]   diff_c;

  // Current slice sum, the result with this slice merged in, and the final
  // flags/saturated value (only meaningful on the last slice).
  always_comb begin
    slice_sum = {1'b0, op_a[int'(idx)*SLICE_W +: SLICE_W]}
              + {1'b0, op_nb[int'(idx)*SLICE_W +: SLICE_W]}
              + {{SLICE_W{1'b0}}, carry};
    res_next = res;
    res_next[int'(idx)*SLICE_W +: SLICE_W] = slice_sum[SLICE_W-1:0];
    // a and b differ in sign exactly when a and ~b agree in sign.
    ovfl_c = (op_a[WIDTH-1] == op_nb[WIDTH-1]) &&
             (res_next[WIDTH-1] != op_a[WIDTH-1]);
    if (sat_q && ovfl_c) begin
      diff_c = {op_a[WIDTH-1], {(WIDTH-1){~op_a[WIDTH-1]}}};
    end else begin
      diff_c = res_next;
    end
  end

  // Control FSM plus operand, carry, slice and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_nb  <= '0;
      res    <= '0;
      sat_q  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      diff   <= '0;
      ovfl   <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_nb <= ~b;
            sat_q <= sat_en;
            carry <= 1'b1;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res   <= res_next;
          carry <= slice_sum[SLICE_W];
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            diff   <= diff_c;
            ovfl   <= ovfl_c;
            borrow <= ~slice_sum[SLICE_W];
            zero   <= (diff_c == '0);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status decodes of the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_sub16.sv
// Self-checking bench for nibble_serial_sub16: directed cases, start handling,
// back-to-back operation, asynchronous reset mid-operation and randomized
// operations scored against an arithmetic reference model.
module tb_nibble_serial_sub16;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sat_en = 1'b0;
  logic         busy, done, ovfl, borrow, zero;
  logic [W-1:0] diff;

  always #5 clk = ~clk;

  nibble_serial_sub16 #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .sat_en (sat_en),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .ovfl   (ovfl),
    .borrow (borrow),
    .zero   (zero)
  );

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  int ops_done = 0;
  logic [W+2:0] exp_q[$];   // {zero, borrow, ovfl, diff}

  // Count done pulses independently of the drivers.
  always @(negedge clk) if (rst_n && done === 1'b1) done_count++;

  // ---------------- reference model ----------------
  // Signed overflow from the true integer difference, borrow from a 17-bit
  // unsigned subtraction.
  function automatic logic [W+2:0] ref_model(input logic [W-1:0] av,
                                             input logic [W-1:0] bv,
                                             input logic sv);
    int sa, sb, d;
    logic [W:0] u;
    logic [W-1:0] r;
    logic o, bw;
    sa = $signed(av);
    sb = $signed(bv);
    d  = sa - sb;
    u  = {1'b0, av} - {1'b0, bv};
    bw = u[W];
    r  = u[W-1:0];
    o  = (d > 32767) || (d < -32768);
    if (sv && o) r = (d > 0) ? 16'h7FFF : 16'h8000;
    return {(r == '0), bw, o, r};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; drives start for one edge and returns at the negedge
  // where done is seen (lat counts cycles from the first RUN cycle).
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, output int lat, output int busy_n);
    a = av; b = bv; sat_en = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (done === 1'b1) ops_done++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, diff, ovfl, borrow, zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h ovfl=%b borrow=%b zero=%b, want all 0",
               busy, done, diff, ovfl, borrow, zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic         sv;
    logic [W-1:0] d;
    logic         o;
    logic         bw;
    logic         z;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[6];
    int lat, busy_n;
    tbl[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].av, tbl[i].bv, tbl[i].sv, lat, busy_n);
      n_checks++;
      if (lat !== 5 || busy_n !== 4) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got done at cycle %0d after %0d busy cycles, want 5 and 4",
                 i, lat, busy_n);
      end
      n_checks++;
      if ({diff, ovfl, borrow, zero} !== {tbl[i].d, tbl[i].o, tbl[i].bw, tbl[i].z}) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got diff=%h ovfl=%b borrow=%b zero=%b, want diff=%h ovfl=%b borrow=%b zero=%b",
                 i, diff, ovfl, borrow, zero, tbl[i].d, tbl[i].o, tbl[i].bw, tbl[i].z);
      end
      // One idle cycle: done must have dropped and results must hold.
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 ||
          {diff, ovfl, borrow, zero} !== {tbl[i].d, tbl[i].o, tbl[i].bw, tbl[i].z}) begin
        n_fail++;
        $display("FAIL directed_hold[%0d]: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h",
                 i, done, busy, diff, tbl[i].d);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    a = 16'h0100; b = 16'h0001; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    // Keep requesting with junk operands during the first three RUN cycles.
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 16'h1111 + 16'h8000); b = 16'h1234; sat_en = 1'b1; start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done === 1'b1) ops_done++;
    n_checks++;
    if (lat !== 5) begin
      n_fail++;
      $display("FAIL ignore_latency: got done at cycle %0d, want 5", lat);
    end
    n_checks++;
    if ({diff, ovfl, borrow, zero} !== {16'h00FF, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_result: got diff=%h ovfl=%b borrow=%b zero=%b, want 00ff 0 0 0",
               diff, ovfl, borrow, zero);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_not_queued: got busy=%b after done, want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n, k;
    do_op(16'h4000, 16'h0001, 1'b0, lat, busy_n);
    n_checks++;
    if (done !== 1'b1 || diff !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b diff=%h, want 1 3fff", done, diff);
    end
    // Request during the DONE cycle.
    a = 16'h0002; b = 16'h0007; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || diff !== 16'h3FFF) begin
      n_fail++;
      $display("FAIL b2b_accept: got done=%b busy=%b diff=%h, want 0 1 3fff (held)",
               done, busy, diff);
    end
    // One DONE cycle plus four RUN cycles separate the two done pulses.
    k = 1;
    busy_n = 0;
    while (done !== 1'b1 && k < 20) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    if (done === 1'b1) ops_done++;
    n_checks++;
    if (k !== 5 || busy_n !== 4) begin
      n_fail++;
      $display("FAIL b2b_spacing: got second done %0d cycles after first with %0d busy cycles, want 5 and 4",
               k, busy_n);
    end
    n_checks++;
    if ({diff, ovfl, borrow, zero} !== {16'hFFFB, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got diff=%h ovfl=%b borrow=%b zero=%b, want fffb 0 1 0",
               diff, ovfl, borrow, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int lat, busy_n, dc;
    a = 16'h00F0; b = 16'h0010; sat_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);             // second RUN cycle
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, ovfl, borrow, zero} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b diff=%h ovfl=%b borrow=%b zero=%b, want all 0",
               busy, done, diff, ovfl, borrow, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dc = done_count;
    repeat (8) @(negedge clk);
    n_checks++;
    if (done_count !== dc || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d done pulses busy=%b after reset, want 0 and 0",
               done_count - dc, busy);
    end
    do_op(16'h0010, 16'h0001, 1'b0, lat, busy_n);
    n_checks++;
    if (lat !== 5 || {diff, ovfl, borrow, zero} !== {16'h000F, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_op: got lat=%0d diff=%h ovfl=%b borrow=%b zero=%b, want 5 000f 0 0 0",
               lat, diff, ovfl, borrow, zero);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [5];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
    corner[3] = 16'h7FFF; corner[4] = 16'h0001;
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  task automatic test_random();
    int lat, busy_n;
    logic [W-1:0] av, bv;
    logic sv;
    logic [W+2:0] exp_v;
    for (int i = 0; i < 1000; i++) begin
      av = pick_operand();
      bv = pick_operand();
      sv = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_model(av, bv, sv));
      do_op(av, bv, sv, lat, busy_n);
      n_checks++;
      if (lat !== 5) begin
        n_fail++;
        $display("FAIL random_latency[%0d]: got done at cycle %0d, want 5", i, lat);
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({zero, borrow, ovfl, diff} !== exp_v) begin
        n_fail++;
        $display("FAIL random_result[%0d]: a=%h b=%h sat=%b got diff=%h ovfl=%b borrow=%b zero=%b, want diff=%h ovfl=%b borrow=%b zero=%b",
                 i, av, bv, sv, diff, ovfl, borrow, zero,
                 exp_v[W-1:0], exp_v[W], exp_v[W+1], exp_v[W+2]);
      end
      // Mix back-to-back requests with idle gaps.
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_count !== ops_done) begin
      n_fail++;
      $display("FAIL done_once_per_start: got %0d done pulses, want %0d", done_count, ops_done);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
